// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Brief    : Shared Wishbone widths, request record and slave FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;

    typedef struct packed {
        logic                     we;
        logic [WB_ADDR_WIDTH-1:0] adr;
        logic [WB_DATA_WIDTH-1:0] dat;
        logic [WB_SEL_WIDTH-1:0]  sel;
    } wb_req_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_req_fifo
//  Brief    : Synchronous request FIFO with flush; push is refused while full.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_req_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  wb_req_t                    data_i,
    input  logic                       pop_i,
    output wb_req_t                    data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               w_do_push;
    logic               w_do_pop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign count_o   = cnt_q;
    assign data_o    = mem_q[rd_q];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (w_do_push) wr_d = wr_q + PTR_W'(1);
            if (w_do_pop)  rd_d = rd_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/wb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mem_slave
//  Brief    : Wishbone B4 pipelined memory slave with in-order ack/err replies.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic                     wb_rty_o,
    output logic                     wb_stall_o
);

    localparam int IDX_LSB = $clog2(WB_SEL_WIDTH);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int HI_LSB  = IDX_LSB + IDX_W;
    localparam int CNT_W   = 3;

    logic [WB_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    wb_state_t                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
    logic [WB_DATA_WIDTH-1:0] hold_q, hold_d;

    wb_req_t                  w_req;
    wb_req_t                  w_head;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                     w_pop;
    logic                     w_mem_we;
    logic                     w_oor;
    logic [IDX_W-1:0]         w_idx;
    logic [WB_DATA_WIDTH-1:0] w_rd_word;
    logic                     w_unused;

    assign w_req = '{we: wb_we_i, adr: wb_adr_i, dat: wb_dat_i, sel: wb_sel_i};

    wb_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_i),
        .flush_i (!wb_cyc_i),
        .push_i  (wb_cyc_i && wb_stb_i),
        .data_i  (w_req),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign w_idx     = w_head.adr[IDX_LSB +: IDX_W];
    assign w_rd_word = mem_q[w_idx];
    assign w_unused  = ^{w_head.adr[IDX_LSB-1:0], w_count};

    generate
        if (HI_LSB < WB_ADDR_WIDTH) begin : g_range_chk
            assign w_oor = |w_head.adr[WB_ADDR_WIDTH-1:HI_LSB];
        end else begin : g_range_full
            assign w_oor = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = '0;
        w_pop    = 1'b0;
        w_mem_we = 1'b0;
        // Dropping cyc abandons everything queued or waiting; no late replies.
        if (!wb_cyc_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_oor) begin
                            err_d = 1'b1;
                        end else if (w_head.we) begin
                            ack_d    = 1'b1;
                            w_mem_we = 1'b1;
                        end else if (RD_LATENCY <= 1) begin
                            ack_d = 1'b1;
                            dat_d = w_rd_word;
                        end else begin
                            // Data is captured at pop so later queued writes cannot leak in.
                            hold_d  = w_rd_word;
                            cnt_d   = CNT_W'(RD_LATENCY - 1);
                            state_d = RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        ack_d   = 1'b1;
                        dat_d   = hold_q;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_mem_we) begin
            for (int b = 0; b < WB_SEL_WIDTH; b++) begin
                if (w_head.sel[b]) mem_q[w_idx][8*b +: 8] <= w_head.dat[8*b +: 8];
            end
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_dat_o   = dat_q;
    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = w_full;

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_mem_slave
//  Brief    : Scoreboard bench for wb_mem_slave (RD_LATENCY 4, FIFO_DEPTH 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_mem_slave;

    localparam int MEM_DEPTH  = 1024;
    localparam int RD_LAT     = 4;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic        ack, err, rty, stall;

    typedef struct {
        bit          err;
        bit          chk_dat;
        logic [31:0] dat;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_resp = 0;
    int   n_stall = 0;
    int   cyc_cnt = 0;

    wb_mem_slave #(
        .MEM_DEPTH  (MEM_DEPTH),
        .RD_LATENCY (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_w),
        .wb_sel_i   (sel),
        .wb_dat_o   (dat_o),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .wb_rty_o   (rty),
        .wb_stall_o (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && stall) n_stall++;
        if (rst_n && (ack || err)) begin
            n_resp++;
            n_cmp++;
            if (ack && err) begin
                n_bad++;
                $display("FAIL resp_both got ack=1 err=1 want exactly one");
            end else if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL resp_unexpected got ack=%0b err=%0b dat=%h want no response", ack, err, dat_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ((err !== e.err) || (e.chk_dat && dat_o !== e.dat) || (e.cyc >= 0 && cyc_cnt != e.cyc)) begin
                    n_bad++;
                    $display("FAIL resp_%s got err=%0b dat=%h cyc=%0d want err=%0b dat=%h cyc=%0d",
                             e.name, err, dat_o, cyc_cnt, e.err, e.dat, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one request, holds it through stalls, records the expected reply.
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit exp_err, input logic [31:0] exp_dat, input bit chk_lat, input string name);
        int   waits = 0;
        exp_t e;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        @(negedge clk);
        while (stall && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (stall) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_stall_timeout got stall=1 want accept", name);
        end else begin
            e.err     = exp_err;
            e.chk_dat = !w;
            e.dat     = exp_dat;
            e.name    = name;
            e.cyc     = chk_lat ? cyc_cnt + 1 + ((w || exp_err) ? 1 : RD_LAT) : -1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check({name, "_drained"}, exp_q.size(), 0);
        idle(2);
    endtask

    initial begin
        int r0, s0;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_w = '0; sel = '0;
        idle(3);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_stall", stall, 0);
        check("rst_dat", dat_o, 0);
        check("rty_tied", rty, 0);
        rst_n = 1'b1;
        idle(2);

        // Full-word write then read back with latency checks.
        issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 1, "wr_10");
        idle(6);
        issue(0, 32'h10, 0, 4'h0, 0, 32'hDEADBEEF, 1, "rd_10");
        drain("t1");

        // Byte-lane merge, sel=0 no-op, byte offset ignored.
        issue(1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, "wr_20_ff");
        issue(1, 32'h20, 32'h11223344, 4'h5, 0, 0, 0, "wr_20_sel5");
        issue(0, 32'h20, 0, 4'h0, 0, 32'hFF22FF44, 0, "rd_20");
        issue(1, 32'h20, 32'h00000000, 4'h0, 0, 0, 0, "wr_20_sel0");
        issue(0, 32'h23, 0, 4'h0, 0, 32'hFF22FF44, 0, "rd_23");
        drain("t2");

        // Read right behind a write to the same word sees the new data.
        issue(1, 32'h30, 32'hCAFEF00D, 4'hF, 0, 0, 0, "wr_30");
        issue(0, 32'h30, 0, 4'h0, 0, 32'hCAFEF00D, 0, "rd_30");
        drain("t3");

        // Six back-to-back reads force stall; replies must stay in order.
        for (int i = 0; i < 6; i++)
            issue(1, 32'h40 + 4*i, 32'hA0A0_0000 + i, 4'hF, 0, 0, 0, "wr_seq");
        drain("t4w");
        s0 = n_stall;
        for (int i = 0; i < 6; i++)
            issue(0, 32'h40 + 4*i, 0, 4'h0, 0, 32'hA0A0_0000 + i, 0, $sformatf("rd_seq%0d", i));
        drain("t4r");
        check("stall_seen", (n_stall > s0) ? 1 : 0, 1);

        // Out-of-range accesses: err only, memory untouched.
        issue(1, 32'h0, 32'h0BADF00D, 4'hF, 0, 0, 0, "wr_0");
        drain("t5w");
        issue(0, 4*MEM_DEPTH, 0, 4'h0, 1, 32'h0, 1, "rd_oor");
        drain("t5r");
        issue(1, 4*MEM_DEPTH, 32'h12345678, 4'hF, 1, 0, 1, "wr_oor");
        issue(0, 32'h0, 0, 4'h0, 0, 32'h0BADF00D, 0, "rd_0_after_oor");
        drain("t5c");

        // Dropping cyc before the first reply discards all three reads.
        r0 = n_resp;
        for (int i = 0; i < 3; i++)
            issue(0, 32'h40 + 4*i, 0, 4'h0, 0, 32'hA0A0_0000 + i, 0, "rd_abort");
        cyc = 1'b0;
        exp_q.delete();
        idle(12);
        check("abort_no_resp", n_resp - r0, 0);
        check("abort_stall", stall, 0);
        issue(0, 32'h10, 0, 4'h0, 0, 32'hDEADBEEF, 1, "rd_after_abort");
        drain("t6");

        // Reset while in RD_WAIT with the FIFO full.
        for (int i = 0; i < 6; i++)
            issue(0, 32'h40 + 4*i, 0, 4'h0, 0, 32'hA0A0_0000 + i, 0, $sformatf("rd_pre_rst%0d", i));
        check("pre_rst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_stall", stall, 0);
        check("rst_async_ack", ack, 0);
        check("rst_async_err", err, 0);
        check("rst_async_dat", dat_o, 0);
        exp_q.delete();
        r0 = n_resp;
        idle(3);
        rst_n = 1'b1;
        idle(15);
        check("post_rst_no_resp", n_resp - r0, 0);
        issue(1, 32'h70, 32'h5A5A1234, 4'hF, 0, 0, 1, "wr_70");
        issue(0, 32'h70, 0, 4'h0, 0, 32'h5A5A1234, 0, "rd_70");
        drain("t7");
        check("rty_end", rty, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
